system_debug_slave_sysclk_mc: RTL and testbench
===============================================

SYSTEM_DEBUG_SLAVE_SYSCLK_MC -- requirements
Module: system_debug_slave_sysclk_mc

Interface
REQ-001 Parameter NUM_CORES, default 1, number of target CPU cores (1..8).
REQ-002 Parameter CSEL_W, default 3, width of the core-select field (NUM_CORES <= 2**CSEL_W).
REQ-003 Parameter SR_W, default 38+CSEL_W, shift-register width; bits [37:0] carry the payload and [SR_W-1:38] carry the core select.
REQ-004 Parameter SYNC_STAGES, default 2, synchronizer depth for vs_uir/vs_udr (2..4).
REQ-005 Parameter TIMEOUT, default 255, WAIT-state cycle limit (1..65535).
REQ-006 clk  input  1  system clock; the block's only clock.
REQ-007 reset_n  input  1  reset; asynchronous assert, active-low.
REQ-008 ir_in  input  2  JTAG IR value, stable around each vs_uir pulse.
REQ-009 sr  input  SR_W  JTAG data shift register, stable around each vs_udr pulse.
REQ-010 vs_uir / vs_udr  input  1 each  update-IR / update-DR indications from the TCK domain, asynchronous to clk.
REQ-011 core_ready  input  NUM_CORES  per-core readiness to accept a strobe.
REQ-012 jdo  output  SR_W  captured shift-register contents.
REQ-013 action  output  10*NUM_CORES  one-cycle strobes; bit c*10+k is strobe k for core c.
REQ-014 busy  output  1  command pending (WAIT state).
REQ-015 overrun / timeout / bad_sel  output  1 each  sticky error flags.
REQ-016 cmd_count  output  16  count of issued commands.

Function
REQ-017 vs_uir and vs_udr each pass through a SYNC_STAGES flop chain; a 0->1 transition at the chain output produces a one-cycle edge pulse (uir_p, udr_p).
REQ-018 On uir_p, ir_q <= ir_in and overrun, timeout and bad_sel clear.
REQ-019 On udr_p in IDLE: jdo <= sr, the pending code is decoded from ir_q and sr, sel <= sr[SR_W-1:38], and the state moves to WAIT.
REQ-020 Strobe index k: 0 ocimem_a, 1 ocimem_b, 2 no_ocimem_a, 3 break_a, 4 break_b, 5 break_c, 6 no_break_a, 7 no_break_b, 8 no_break_c, 9 tracectrl.
REQ-021 Decode for ir_q=0: sr[35]=1 gives k=1; sr[35:34]=01 gives k=0; sr[35:34]=00 gives k=2.
REQ-022 Decode for ir_q=2: sr[37:36]=00 gives k=6; 01 gives k=3; 10 gives k=4 if sr[35] else k=7; 11 gives k=5 if sr[35] else k=8.
REQ-023 Decode for ir_q=3: sr[15]=1 gives k=9, else no strobe. For ir_q=1: no strobe.
REQ-024 A no-strobe decode captures jdo and returns to IDLE without entering WAIT; cmd_count is unchanged.
REQ-025 sel >= NUM_CORES: jdo is captured, bad_sel is set, and the command is dropped (state stays IDLE).
REQ-026 In WAIT, when core_ready[sel]=1, exactly one action bit (sel*10+k) pulses high for one cycle, cmd_count increments (wrapping at 16 bits), and the state returns to IDLE; earliest strobe is one cycle after capture.
REQ-027 udr_p while in WAIT: jdo and the pending command are unchanged and overrun is set.
REQ-028 uir_p and udr_p in the same cycle: decode uses the old ir_q; ir_q updates in that same cycle.
REQ-029 busy = (state == WAIT).

Reset
REQ-030 reset_n low asynchronously sets: synchronizer flops, ir_q, jdo, sel, cmd_count and all flags to 0; action all 0; state IDLE.
REQ-031 Reset asserted during WAIT discards the pending command; no strobe is emitted after release.
REQ-032 On release, a vs_udr already high produces no edge pulse until it has fallen and risen again.

Configuration
REQ-033 Macro SYSTEM_DEBUG_SLAVE_TIMEOUT_EN defined: a 16-bit counter runs in WAIT; after TIMEOUT cycles with core_ready[sel]=0 the command is dropped, timeout is set, and the state returns to IDLE.
REQ-034 Macro undefined: WAIT persists until core_ready[sel]=1; timeout is held at 0 and no counter is synthesized.

Verification
REQ-035 NUM_CORES=1, uir with ir_in=0, then udr with sr[35:34]=01 and core_ready=1 -> action[0] pulses exactly one cycle, SYNC_STAGES+2 cycles after the vs_udr rise; cmd_count=1.
REQ-036 NUM_CORES=4, ir=2, sr[37:35]=111, sel=2, core_ready=0 for 5 cycles then 1 -> busy high for 5 cycles, then action[25] pulses once.
REQ-037 sel=5 with NUM_CORES=4 -> bad_sel=1, no action bit, busy never asserts; next uir pulse clears bad_sel.
REQ-038 Second udr pulse during WAIT with different sr -> overrun=1, jdo retains the first value, exactly one strobe for the first command.
REQ-039 TIMEOUT_EN defined, TIMEOUT=10, core_ready held 0 -> timeout=1 after 10 WAIT cycles, back in IDLE, no strobe; without the macro, busy stays high indefinitely.
REQ-040 reset_n pulsed low during WAIT -> all outputs 0 immediately, no strobe after release.

Source files
------------

// File: rtl/system_debug_slave_sysclk_mc.sv
// System-clock side of a JTAG debug slave.
// The update-IR and update-DR indications arrive from the TCK domain and are synchronized here.
// Each captured command is decoded into one of ten per-core strobes.
// A strobe is issued once the selected core reports ready.
// Optional feature macro: SYSTEM_DEBUG_SLAVE_TIMEOUT_EN. It enables a WAIT-state timeout.
module system_debug_slave_sysclk_mc #(
  parameter int unsigned NUM_CORES   = 1,
  parameter int unsigned CSEL_W      = 3,
  parameter int unsigned SR_W        = 38 + CSEL_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [1:0]                ir_in,
  input  logic [SR_W-1:0]           sr,
  input  logic                      vs_uir,
  input  logic                      vs_udr,
  input  logic [NUM_CORES-1:0]      core_ready,
  output logic [SR_W-1:0]           jdo,
  output logic [10*NUM_CORES-1:0]   action,
  output logic                      busy,
  output logic                      overrun,
  output logic                      timeout,
  output logic                      bad_sel,
  output logic [15:0]               cmd_count
);

  localparam int unsigned K_W      = 4;
  localparam int unsigned N_STROBE = 10;
  localparam int unsigned ACT_W    = N_STROBE * NUM_CORES;
  localparam int unsigned CNT_W    = 16;
  localparam logic [CSEL_W:0] NUM_CORES_W = (CSEL_W + 1)'(NUM_CORES);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // Synchronizer chains with edge detection.
  // arm_q blocks a spurious edge from a level that was already high when reset released.
  logic [SYNC_STAGES-1:0] uir_sync_q, udr_sync_q, fill_q;
  logic uir_prev_q, udr_prev_q, uir_arm_q, udr_arm_q;
  logic uir_out, udr_out, uir_p, udr_p;

  assign uir_out = uir_sync_q[SYNC_STAGES-1];
  assign udr_out = udr_sync_q[SYNC_STAGES-1];
  assign uir_p   = uir_out & ~uir_prev_q & uir_arm_q;
  assign udr_p   = udr_out & ~udr_prev_q & udr_arm_q;

  // Synchronizer, fill tracker and edge-arming flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync_q <= '0;
      udr_sync_q <= '0;
      fill_q     <= '0;
      uir_prev_q <= 1'b0;
      udr_prev_q <= 1'b0;
      uir_arm_q  <= 1'b0;
      udr_arm_q  <= 1'b0;
    end else begin
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      uir_prev_q <= uir_out;
      udr_prev_q <= udr_out;
      uir_arm_q  <= uir_arm_q | (fill_q[SYNC_STAGES-1] & ~uir_out);
      udr_arm_q  <= udr_arm_q | (fill_q[SYNC_STAGES-1] & ~udr_out);
    end
  end

  state_t            state_q, state_d;
  logic [1:0]        ir_q, ir_d;
  logic [SR_W-1:0]   jdo_q, jdo_d;
  logic [CSEL_W-1:0] sel_q, sel_d;
  logic [K_W-1:0]    code_q, code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACT_W-1:0]  action_q, action_d;
  logic              overrun_q, overrun_d;
  logic              bad_sel_q, bad_sel_d;
`ifdef SYSTEM_DEBUG_SLAVE_TIMEOUT_EN
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic              timeout_q, timeout_d;
`endif

  logic              dec_valid;
  logic [K_W-1:0]    dec_k;
  logic [CSEL_W-1:0] sr_sel;
  logic              ready_sel;

  assign sr_sel = CSEL_W'(sr[SR_W-1:38]);

  // Decode the strobe index from the current IR and the data register.
  always_comb begin
    dec_valid = 1'b0;
    dec_k     = '0;
    case (ir_q)
      2'd0: begin
        dec_valid = 1'b1;
        if (sr[35])      dec_k = K_W'(1);
        else if (sr[34]) dec_k = K_W'(0);
        else             dec_k = K_W'(2);
      end
      2'd2: begin
        dec_valid = 1'b1;
        case (sr[37:36])
          2'b00:   dec_k = K_W'(6);
          2'b01:   dec_k = K_W'(3);
          2'b10:   dec_k = sr[35] ? K_W'(4) : K_W'(7);
          default: dec_k = sr[35] ? K_W'(5) : K_W'(8);
        endcase
      end
      2'd3: begin
        dec_valid = sr[15];
        dec_k     = K_W'(9);
      end
      default: begin
        dec_valid = 1'b0;
        dec_k     = '0;
      end
    endcase
  end

  // Readiness of the core selected by the pending command.
  always_comb begin
    ready_sel = 1'b0;
    for (int c = 0; c < int'(NUM_CORES); c++) begin
      if (sel_q == CSEL_W'(c)) ready_sel = core_ready[c];
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    jdo_d     = jdo_q;
    sel_d     = sel_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    action_d  = '0;
    overrun_d = overrun_q;
    bad_sel_d = bad_sel_q;
`ifdef SYSTEM_DEBUG_SLAVE_TIMEOUT_EN
    tmo_d     = tmo_q;
    timeout_d = timeout_q;
`endif

    if (uir_p) begin
      ir_d      = ir_in;
      overrun_d = 1'b0;
      bad_sel_d = 1'b0;
`ifdef SYSTEM_DEBUG_SLAVE_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
    end

    case (state_q)
      IDLE: begin
        if (udr_p) begin
          jdo_d = sr;
          sel_d = sr_sel;
          if ({1'b0, sr_sel} >= NUM_CORES_W) begin
            bad_sel_d = 1'b1;
          end else if (dec_valid) begin
            code_d  = dec_k;
            state_d = WAIT;
`ifdef SYSTEM_DEBUG_SLAVE_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end
      end
      WAIT: begin
        if (udr_p) overrun_d = 1'b1;
        if (ready_sel) begin
          for (int c = 0; c < int'(NUM_CORES); c++) begin
            for (int kk = 0; kk < int'(N_STROBE); kk++) begin
              if (sel_q == CSEL_W'(c) && code_q == K_W'(kk)) action_d[c*N_STROBE+kk] = 1'b1;
            end
          end
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
`ifdef SYSTEM_DEBUG_SLAVE_TIMEOUT_EN
        end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      jdo_q     <= '0;
      sel_q     <= '0;
      code_q    <= '0;
      cnt_q     <= '0;
      action_q  <= '0;
      overrun_q <= 1'b0;
      bad_sel_q <= 1'b0;
`ifdef SYSTEM_DEBUG_SLAVE_TIMEOUT_EN
      tmo_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      jdo_q     <= jdo_d;
      sel_q     <= sel_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      action_q  <= action_d;
      overrun_q <= overrun_d;
      bad_sel_q <= bad_sel_d;
`ifdef SYSTEM_DEBUG_SLAVE_TIMEOUT_EN
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign jdo       = jdo_q;
  assign action    = action_q;
  assign busy      = (state_q == WAIT);
  assign overrun   = overrun_q;
  assign bad_sel   = bad_sel_q;
  assign cmd_count = cnt_q;
`ifdef SYSTEM_DEBUG_SLAVE_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_system_debug_slave_sysclk_mc.sv
// Directed, table-driven bench for system_debug_slave_sysclk_mc (4 cores, 2 sync stages).
module tb_system_debug_slave_sysclk_mc;

  localparam int unsigned NC   = 4;
  localparam int unsigned CW   = 3;
  localparam int unsigned SW   = 38 + CW;
  localparam int unsigned SS   = 2;
  localparam int unsigned TMO  = 10;
  localparam int unsigned AW   = 10 * NC;

  logic          clk, reset_n;
  logic [1:0]    ir_in;
  logic [SW-1:0] sr;
  logic          vs_uir, vs_udr;
  logic [NC-1:0] core_ready;
  logic [SW-1:0] jdo;
  logic [AW-1:0] action;
  logic          busy, overrun, timeout, bad_sel;
  logic [15:0]   cmd_count;

  system_debug_slave_sysclk_mc #(
    .NUM_CORES(NC), .CSEL_W(CW), .SR_W(SW), .SYNC_STAGES(SS), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_uir(vs_uir), .vs_udr(vs_udr), .core_ready(core_ready),
    .jdo(jdo), .action(action), .busy(busy), .overrun(overrun),
    .timeout(timeout), .bad_sel(bad_sel), .cmd_count(cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] ir;
    logic [2:0] sel;
    logic [2:0] b37_35;
    logic       b34;
    logic       b15;
    int         exp_bit;
    logic       exp_bad;
  } vec_t;

  function automatic logic [SW-1:0] mk_sr(input logic [2:0] sel, input logic [2:0] hi,
                                          input logic b34, input logic b15, input int seed);
    return {sel, hi, b34, 18'(seed * 97), b15, 15'(seed * 4661)};
  endfunction

  function automatic logic [AW-1:0] bit_of(input int b);
    logic [AW-1:0] v;
    v = '0;
    if (b >= 0) v[b] = 1'b1;
    return v;
  endfunction

  task automatic do_uir(input logic [1:0] ir);
    @(posedge clk); #1;
    ir_in = ir; vs_uir = 1'b1;
    repeat (4) @(posedge clk);
    #1 vs_uir = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic udr_raise(input logic [SW-1:0] s);
    @(posedge clk); #1;
    sr = s; vs_udr = 1'b1;
  endtask

  task automatic udr_drop();
    repeat (3) @(posedge clk);
    #1 vs_udr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input string name);
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
    chk(name, 64'(busy), 64'd1);
  endtask

  vec_t vt[13];
  int   exp_cnt;

  initial begin
    logic [SW-1:0] s, s1, s2;
    logic [AW-1:0] seen;
    int pulses, busy_seen, first, bcnt;

    vt[0]  = '{2'd0, 3'd0, 3'b000, 1'b1, 1'b0, 0,  1'b0};
    vt[1]  = '{2'd0, 3'd1, 3'b001, 1'b0, 1'b0, 11, 1'b0};
    vt[2]  = '{2'd0, 3'd3, 3'b000, 1'b0, 1'b0, 32, 1'b0};
    vt[3]  = '{2'd2, 3'd0, 3'b000, 1'b0, 1'b0, 6,  1'b0};
    vt[4]  = '{2'd2, 3'd1, 3'b010, 1'b0, 1'b0, 13, 1'b0};
    vt[5]  = '{2'd2, 3'd2, 3'b101, 1'b0, 1'b0, 24, 1'b0};
    vt[6]  = '{2'd2, 3'd2, 3'b100, 1'b0, 1'b0, 27, 1'b0};
    vt[7]  = '{2'd2, 3'd2, 3'b111, 1'b0, 1'b0, 25, 1'b0};
    vt[8]  = '{2'd2, 3'd3, 3'b110, 1'b0, 1'b0, 38, 1'b0};
    vt[9]  = '{2'd3, 3'd1, 3'b000, 1'b0, 1'b1, 19, 1'b0};
    vt[10] = '{2'd3, 3'd1, 3'b000, 1'b0, 1'b0, -1, 1'b0};
    vt[11] = '{2'd1, 3'd2, 3'b111, 1'b1, 1'b1, -1, 1'b0};
    vt[12] = '{2'd0, 3'd5, 3'b000, 1'b1, 1'b0, -1, 1'b1};

    reset_n = 1'b1; ir_in = '0; sr = '0; vs_uir = 1'b0; vs_udr = 1'b0; core_ready = '0;
    #2 reset_n = 1'b0;
    #3;
    chk("rst_jdo", 64'(jdo), 64'd0);
    chk("rst_action", 64'(action), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flags", 64'({overrun, timeout, bad_sel}), 64'd0);
    chk("rst_cnt", 64'(cmd_count), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    exp_cnt = 0;

    // Strobe latency: vs_udr rise to action[0].
    core_ready = '1;
    do_uir(2'd0);
    udr_raise(mk_sr(3'd0, 3'b000, 1'b1, 1'b0, 55));
    first = -1; pulses = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); @(negedge clk);
      if (action[0]) begin
        pulses++;
        if (first < 0) first = n;
      end
      if (n == 3) vs_udr = 1'b0;
    end
    exp_cnt++;
    chk("lat_cycles", 64'(first), 64'(SS + 2));
    chk("lat_pulses", 64'(pulses), 64'd1);
    chk("lat_cnt", 64'(cmd_count), 64'(exp_cnt));

    // Decode table across IRs, cores and selects.
    for (int i = 0; i < 13; i++) begin
      do_uir(vt[i].ir);
      core_ready = '1;
      s = mk_sr(vt[i].sel, vt[i].b37_35, vt[i].b34, vt[i].b15, i + 1);
      udr_raise(s);
      seen = '0; pulses = 0; busy_seen = 0;
      for (int j = 0; j < 12; j++) begin
        @(negedge clk);
        if (action != '0) pulses++;
        seen |= action;
        if (busy) busy_seen = 1;
        if (j == 3) vs_udr = 1'b0;
      end
      if (vt[i].exp_bit >= 0) exp_cnt++;
      chk($sformatf("v%0d_action", i), 64'(seen), 64'(bit_of(vt[i].exp_bit)));
      chk($sformatf("v%0d_pulses", i), 64'(pulses), 64'((vt[i].exp_bit >= 0) ? 1 : 0));
      chk($sformatf("v%0d_busy", i), 64'(busy_seen), 64'((vt[i].exp_bit >= 0) ? 1 : 0));
      chk($sformatf("v%0d_jdo", i), 64'(jdo), 64'(s));
      chk($sformatf("v%0d_cnt", i), 64'(cmd_count), 64'(exp_cnt));
      chk($sformatf("v%0d_bad_sel", i), 64'(bad_sel), 64'(vt[i].exp_bad));
    end
    do_uir(2'd2);
    chk("bad_sel_clear", 64'(bad_sel), 64'd0);

    // Busy for five cycles while core 2 is not ready.
    core_ready = '0;
    udr_raise(mk_sr(3'd2, 3'b111, 1'b0, 1'b0, 77));
    bcnt = 0; pulses = 0; seen = '0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (action != '0) pulses++;
      seen |= action;
      if (busy) bcnt++;
      if (j == 3) vs_udr = 1'b0;
      if (busy && bcnt == 5) core_ready = '1;
    end
    exp_cnt++;
    chk("wait_busy_cycles", 64'(bcnt), 64'd5);
    chk("wait_action", 64'(seen), 64'(bit_of(25)));
    chk("wait_pulses", 64'(pulses), 64'd1);

    // Second update during WAIT: overrun, first command survives.
    do_uir(2'd0);
    core_ready = '0;
    s1 = mk_sr(3'd1, 3'b001, 1'b0, 1'b0, 3);
    s2 = mk_sr(3'd2, 3'b000, 1'b1, 1'b0, 9);
    udr_raise(s1);
    udr_drop();
    wait_busy("ovr_busy");
    udr_raise(s2);
    udr_drop();
    chk("ovr_flag", 64'(overrun), 64'd1);
    chk("ovr_jdo", 64'(jdo), 64'(s1));
    chk("ovr_still_busy", 64'(busy), 64'd1);
    seen = '0; pulses = 0;
    core_ready = '1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (action != '0) pulses++;
      seen |= action;
    end
    exp_cnt++;
    chk("ovr_action", 64'(seen), 64'(bit_of(11)));
    chk("ovr_pulses", 64'(pulses), 64'd1);
    chk("ovr_cnt", 64'(cmd_count), 64'(exp_cnt));

    // Core never ready.
    core_ready = '0;
    udr_raise(mk_sr(3'd0, 3'b000, 1'b1, 1'b0, 21));
    udr_drop();
    wait_busy("tmo_busy");
    seen = '0;
`ifdef SYSTEM_DEBUG_SLAVE_TIMEOUT_EN
    bcnt = 0;
    for (int j = 0; j < 40 && busy; j++) begin
      bcnt++;
      seen |= action;
      @(negedge clk);
    end
    chk("tmo_flag", 64'(timeout), 64'd1);
    chk("tmo_idle", 64'(busy), 64'd0);
    chk("tmo_action", 64'(seen), 64'd0);
    udr_raise(mk_sr(3'd0, 3'b000, 1'b1, 1'b0, 22));
    udr_drop();
    wait_busy("tmo_rebusy");
`else
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      seen |= action;
    end
    chk("hang_busy", 64'(busy), 64'd1);
    chk("hang_action", 64'(seen), 64'd0);
    chk("hang_timeout", 64'(timeout), 64'd0);
`endif

    // Reset during WAIT with vs_udr left high across release.
    @(posedge clk); #1;
    vs_udr = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_jdo", 64'(jdo), 64'd0);
    chk("mrst_cnt", 64'(cmd_count), 64'd0);
    chk("mrst_flags", 64'({overrun, timeout, bad_sel}), 64'd0);
    chk("mrst_action", 64'(action), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    core_ready = '1;
    seen = '0; busy_seen = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      seen |= action;
      if (busy) busy_seen = 1;
    end
    chk("rel_action", 64'(seen), 64'd0);
    chk("rel_busy", 64'(busy_seen), 64'd0);
    chk("rel_jdo", 64'(jdo), 64'd0);
    s = mk_sr(3'd3, 3'b000, 1'b1, 1'b0, 40);
    #1 vs_udr = 1'b0;
    repeat (4) @(posedge clk);
    udr_raise(s);
    seen = '0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      seen |= action;
    end
    vs_udr = 1'b0;
    chk("rearm_jdo", 64'(jdo), 64'(s));
    chk("rearm_action", 64'(seen), 64'(bit_of(30)));
    chk("rearm_cnt", 64'(cmd_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
